// File: rtl/alu_a_bus_sequencer_pkg.sv
// alu_seq_pkg: shared encodings for the ALU A-bus sequencer.
//   - A-mux select codes, ALU operation codes
//   - opcode enum accepted on the start handshake
//   - sequencer state enum
//   - is_valid_opcode() helper used by the IDLE-state accept logic
package alu_seq_pkg;

    localparam int unsigned ALU_DATA_W = 18;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_IDR  = 3'd1,
        SEL_MDR  = 3'd2,
        SEL_RCOL = 3'd3,
        SEL_RROW = 3'd4
    } a_sel_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_INC  = 3'd2,
        ALU_DEC  = 3'd3
    } alu_op_e;

    typedef enum logic [3:0] {
        OPC_LDAC = 4'd1,
        OPC_ADDM = 4'd2,
        OPC_INCC = 4'd3,
        OPC_INCR = 4'd4,
        OPC_IDX  = 4'd5,
        OPC_DJNZ = 4'd6
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC1 = 3'd1,
        ST_EXEC2 = 3'd2,
        ST_LOOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic is_valid_opcode(input logic [3:0] opc);
        return (opc >= 4'(OPC_LDAC)) && (opc <= 4'(OPC_DJNZ));
    endfunction

endpackage

// File: rtl/alu_a_bus_sequencer_decode.sv
// alu_seq_decode: combinational Moore decode of sequencer state plus latched
// opcode into datapath controls.
//   state      in   current sequencer state
//   opcode     in   opcode latched at the accepted start
//   a_sel      out  ALU A mux select
//   alu_op     out  ALU operation
//   write_ac   out  AC write enable
//   write_rcol out  Rcol write enable
//   write_rrow out  Rrow write enable
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  state_e     state,
    input  logic [3:0] opcode,
    output logic [2:0] a_sel,
    output logic [2:0] alu_op,
    output logic       write_ac,
    output logic       write_rcol,
    output logic       write_rrow
);

    always_comb begin
        a_sel      = SEL_ZERO;
        alu_op     = ALU_PASS;
        write_ac   = 1'b0;
        write_rcol = 1'b0;
        write_rrow = 1'b0;
        case (state)
            ST_EXEC1: begin
                case (opcode)
                    OPC_LDAC: begin a_sel = SEL_IDR;  alu_op = ALU_PASS; write_ac   = 1'b1; end
                    OPC_ADDM: begin a_sel = SEL_MDR;  alu_op = ALU_ADD;  write_ac   = 1'b1; end
                    OPC_INCC: begin a_sel = SEL_RCOL; alu_op = ALU_INC;  write_rcol = 1'b1; end
                    OPC_INCR: begin a_sel = SEL_RROW; alu_op = ALU_INC;  write_rrow = 1'b1; end
                    OPC_IDX:  begin a_sel = SEL_RROW; alu_op = ALU_PASS; write_ac   = 1'b1; end
                    default: ;
                endcase
            end
            // Only IDX reaches EXEC2: AC = Rrow (from EXEC1) + Rcol.
            ST_EXEC2: begin
                a_sel    = SEL_RCOL;
                alu_op   = ALU_ADD;
                write_ac = 1'b1;
            end
            ST_LOOP: begin
                a_sel      = SEL_RCOL;
                alu_op     = ALU_DEC;
                write_rcol = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_a_bus_sequencer.sv
// alu_a_bus_sequencer: multi-cycle control sequencer for the 18-bit ALU A-bus
// datapath (IDR, MDR, Rcol, Rrow -> A mux -> ALU, B operand = AC).
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   request, accepted only in IDLE
//   opcode     in   operation, sampled on accepted start
//   alu_z      in   ALU zero flag of the current-cycle result
//   a_sel      out  ALU A mux select
//   alu_op     out  ALU operation
//   write_ac   out  AC write enable
//   write_rcol out  Rcol write enable
//   write_rrow out  Rrow write enable
//   busy       out  high whenever not IDLE
//   done       out  one-cycle completion pulse
//   err        out  sticky error until the next accepted start or reset
module alu_a_bus_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int unsigned DATA_W   = ALU_DATA_W,
    parameter  int unsigned MAX_ITER = 256,
    localparam int unsigned CNT_W    = $clog2(MAX_ITER)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       alu_z,
    output logic [2:0] a_sel,
    output logic [2:0] alu_op,
    output logic       write_ac,
    output logic       write_rcol,
    output logic       write_rrow,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // The controller has no datapath of its own; the width only has to agree
    // with the package, and the loop counter needs at least one bit.
    if (DATA_W != ALU_DATA_W || MAX_ITER < 2) begin : g_bad_params
        $error("alu_a_bus_sequencer: unsupported DATA_W/MAX_ITER");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_ITER - 1);

    state_e           state;
    logic [3:0]       opc_q;
    logic [CNT_W-1:0] iter_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            opc_q    <= '0;
            iter_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opc_q    <= opcode;
                        iter_cnt <= '0;
                        if (!is_valid_opcode(opcode)) begin
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= (opcode == OPC_DJNZ) ? ST_LOOP : ST_EXEC1;
                        end
                    end
                end
                ST_EXEC1: state <= (opc_q == OPC_IDX) ? ST_EXEC2 : ST_DONE;
                ST_EXEC2: state <= ST_DONE;
                // alu_z reflects this cycle's Rcol-1, so a zero result ends
                // the loop on the same cycle its write lands.
                ST_LOOP: begin
                    if (alu_z) begin
                        state <= ST_DONE;
                    end else if (iter_cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        iter_cnt <= iter_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    alu_seq_decode u_decode (
        .state      (state),
        .opcode     (opc_q),
        .a_sel      (a_sel),
        .alu_op     (alu_op),
        .write_ac   (write_ac),
        .write_rcol (write_rcol),
        .write_rrow (write_rrow)
    );

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_a_bus_sequencer.sv
// Scoreboard bench for alu_a_bus_sequencer with a behavioural 18-bit datapath
// (IDR, MDR, Rcol, Rrow, AC and ALU) wrapped around the DUT.
module tb_alu_a_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  opcode;
    logic        alu_z;
    logic [2:0]  a_sel;
    logic [2:0]  alu_op;
    logic        write_ac, write_rcol, write_rrow;
    logic        busy, done, err;

    always #5 clk = ~clk;

    alu_a_bus_sequencer #(.MAX_ITER(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .alu_z      (alu_z),
        .a_sel      (a_sel),
        .alu_op     (alu_op),
        .write_ac   (write_ac),
        .write_rcol (write_rcol),
        .write_rrow (write_rrow),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // ---------------- datapath model ----------------
    logic [17:0] idr, mdr, rcol, rrow, ac, a_val, alu_res;
    logic        preload;
    logic [17:0] pre_rcol;

    always_comb begin
        case (a_sel)
            3'd1:    a_val = idr;
            3'd2:    a_val = mdr;
            3'd3:    a_val = rcol;
            3'd4:    a_val = rrow;
            default: a_val = '0;
        endcase
        case (alu_op)
            3'd1:    alu_res = a_val + ac;
            3'd2:    alu_res = a_val + 18'd1;
            3'd3:    alu_res = a_val - 18'd1;
            default: alu_res = a_val;
        endcase
        alu_z = (alu_res == '0);
    end

    always @(posedge clk) begin
        if (preload) begin
            idr  <= 18'd23;
            mdr  <= 18'd19;
            rcol <= pre_rcol;
            rrow <= 18'd54;
            ac   <= 18'd0;
        end else begin
            if (write_ac)   ac   <= alu_res;
            if (write_rcol) rcol <= alu_res;
            if (write_rrow) rrow <= alu_res;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          lat;
        logic        err;
        int          wr;
        logic [17:0] ac;
        logic [17:0] rcol;
        logic [17:0] rrow;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and write cycles per operation, pops and
    // compares on every done pulse.
    int cyc = 0;
    int wr  = 0;
    always @(negedge clk) begin
        if (!busy) begin
            cyc = 0;
            wr  = 0;
        end else begin
            cyc++;
            if (write_ac || write_rcol || write_rrow) wr++;
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", cyc, e.lat);
                    chk("err", err, e.err);
                    chk("write_cycles", wr, e.wr);
                    chk("ac", ac, e.ac);
                    chk("rcol", rcol, e.rcol);
                    chk("rrow", rrow, e.rrow);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_preload(input logic [17:0] rc);
        @(negedge clk);
        preload  = 1'b1;
        pre_rcol = rc;
        @(posedge clk);
        #1 preload = 1'b0;
    endtask

    // Presents start for one edge and pushes the expected result.
    task automatic issue(input logic [3:0] op, input int lat, input logic e_err,
                         input int e_wr, input logic [17:0] e_ac,
                         input logic [17:0] e_rcol, input logic [17:0] e_rrow);
        exp_t e;
        e.lat = lat; e.err = e_err; e.wr = e_wr;
        e.ac = e_ac; e.rcol = e_rcol; e.rrow = e_rrow;
        @(negedge clk);
        q.push_back(e);
        start  = 1'b1;
        opcode = op;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = '0;
        preload = 1'b0; pre_rcol = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_a_sel", a_sel, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_writes", {write_ac, write_rcol, write_rrow}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_err", err, 0);

        // LDAC then ADDM
        do_preload(18'd65);
        issue(4'd1, 2, 1'b0, 1, 18'd23, 18'd65, 18'd54);
        wait_done("to_ldac", 20);
        issue(4'd2, 2, 1'b0, 1, 18'd42, 18'd65, 18'd54);
        wait_done("to_addm", 20);

        // IDX, INCR, INCC
        do_preload(18'd65);
        issue(4'd5, 3, 1'b0, 2, 18'd119, 18'd65, 18'd54);
        wait_done("to_idx", 20);
        issue(4'd4, 2, 1'b0, 1, 18'd119, 18'd65, 18'd55);
        wait_done("to_incr", 20);
        issue(4'd3, 2, 1'b0, 1, 18'd119, 18'd66, 18'd55);
        wait_done("to_incc", 20);

        // DJNZ Rcol=3: loop 3 cycles, Rcol ends at 0
        do_preload(18'd3);
        issue(4'd6, 4, 1'b0, 3, 18'd0, 18'd0, 18'd54);
        wait_done("to_djnz3", 20);

        // DJNZ Rcol=0: wraps, aborts after 256 loop cycles; starts ignored
        do_preload(18'd0);
        issue(4'd6, 257, 1'b1, 256, 18'd0, 18'h3FF00, 18'd54);
        repeat (10) @(negedge clk);
        start = 1'b1; opcode = 4'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1; opcode = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("to_djnz0", 400);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);

        // LDAC clears err; start held through EXEC1 and DONE is ignored
        issue(4'd1, 2, 1'b0, 1, 18'd23, 18'h3FF00, 18'd54);
        start = 1'b1; opcode = 4'd9;
        @(negedge clk);
        chk("err_clear", err, 0);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("to_ldac2", 20);
        repeat (3) @(negedge clk);

        // invalid opcodes
        issue(4'd9, 1, 1'b1, 0, 18'd23, 18'h3FF00, 18'd54);
        wait_done("to_op9", 20);
        issue(4'd0, 1, 1'b1, 0, 18'd23, 18'h3FF00, 18'd54);
        wait_done("to_op0", 20);
        issue(4'd15, 1, 1'b1, 0, 18'd23, 18'h3FF00, 18'd54);
        wait_done("to_op15", 20);

        // reset in the 2nd LOOP cycle of a DJNZ: no done afterwards
        do_preload(18'd65);
        @(negedge clk);
        start = 1'b1; opcode = 4'd6;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_a_sel", a_sel, 0);
        chk("abort_alu_op", alu_op, 0);
        chk("abort_writes", {write_ac, write_rcol, write_rrow}, 0);
        chk("abort_busy_done_err", {busy, done, err}, 0);
        repeat (6) @(negedge clk);

        do_preload(18'd65);
        issue(4'd1, 2, 1'b0, 1, 18'd23, 18'd65, 18'd54);
        wait_done("to_after_reset", 20);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_a_bus_sequencer.md
Name: alu_a_bus_sequencer

Overview:
Multi-cycle control sequencer for the 18-bit ALU A-bus datapath (IDR, MDR, Rcol, Rrow → ALU A mux → ALU, B operand = AC).
- Accepts one opcode per start handshake.
- Drives mux select, ALU op and register write enables cycle by cycle, including a data-dependent decrement loop on Rcol.
- Signals done/err back to the fetch/decode control.

Parameters:
DATA_W, 18, datapath width (documentation/package consistency only; no datapath inside)
MAX_ITER, 256, maximum LOOP-state cycles before forced abort
CNT_W, $clog2(MAX_ITER), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; accepted only in IDLE
opcode  in  4  operation, sampled on accepted start
alu_z  in  1  ALU zero flag of current-cycle result (combinational from ALU)
a_sel  out  3  ALU A mux select: 0 zero, 1 IDR dout1, 2 MDR, 3 Rcol, 4 Rrow, 5-7 reserved (never driven)
alu_op  out  3  0 PASS, 1 ADD, 2 INC, 3 DEC
write_ac  out  1  AC write enable
write_rcol  out  1  Rcol write enable
write_rrow  out  1  Rrow write enable
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  error status, sticky until next accepted start or reset

Behaviour:
- Reset (synchronous, active-high): state IDLE, iteration counter 0, err 0. All outputs 0: a_sel=0, alu_op=PASS, all writes 0, busy=0, done=0.
- Reset asserted mid-operation aborts at that edge: no further writes, no done pulse.
- Outputs are Moore-decoded from state plus latched opcode. A write enable asserted in a cycle makes its target register capture at the end of that cycle.
- States: IDLE, EXEC1, EXEC2, LOOP, DONE.
- IDLE: start=1 latches opcode, clears err and counter, then goes to EXEC1 (valid opcode) or DONE with err=1 (invalid opcode). start while busy is ignored, with no queuing.
- Opcodes and the controls each state drives:
  - 1 LDAC: EXEC1 sel=1, PASS, write_ac → DONE.
  - 2 ADDM: EXEC1 sel=2, ADD, write_ac → DONE.
  - 3 INCC: EXEC1 sel=3, INC, write_rcol → DONE.
  - 4 INCR: EXEC1 sel=4, INC, write_rrow → DONE.
  - 5 IDX: EXEC1 sel=4, PASS, write_ac → EXEC2. EXEC2 sel=3, ADD, write_ac → DONE. Result: AC = Rrow + Rcol.
  - 6 DJNZ: LOOP every cycle drives sel=3, DEC, write_rcol.
    - alu_z=1 → DONE with err=0.
    - Otherwise, if counter == MAX_ITER-1 → DONE with err=1.
    - Otherwise the counter increments and the sequencer stays in LOOP.
    - DJNZ goes straight from IDLE to LOOP (no EXEC1).
  - 0 and 7-15: invalid, no writes.
- DONE: done=1 for one cycle, busy=1, no writes → IDLE. A start during DONE is ignored.
- Latency: single-op = start edge + 2 cycles to done (EXEC1, DONE); IDX = 3; DJNZ = N+1 for Rcol=N (1≤N≤MAX_ITER).
- Boundary conditions:
  - DJNZ with Rcol=0: the decrement wraps to 0x3FFFF and alu_z stays 0, so the loop aborts after MAX_ITER cycles with err=1.
  - DJNZ with Rcol=1 exits after 1 LOOP cycle.
  - alu_z is ignored outside LOOP.

Decomposition:
- Package alu_seq_pkg holds a_sel codes, alu_op codes, the opcode enum and the state enum.
- One natural sub-module, alu_seq_decode: combinational state + opcode → a_sel/alu_op/write decode.
- FSM and counter stay in the top-level block.

Test Plan:
- Datapath preload for every test: IDR=23, MDR=19, Rcol=65, Rrow=54.
- LDAC: start with opcode=1 → EXEC1 with a_sel=1, write_ac, AC=23. Then ADDM (opcode=2) → AC=42. done pulses exactly once per op, at start+2.
- IDX (opcode=5): a_sel sequence 4 then 3, write_ac in both cycles → AC=119. done at start+3. INCR then gives Rrow=55.
- DJNZ with Rcol=3: three LOOP cycles, Rcol 2,1,0. alu_z in the third → done at start+4, err=0.
- DJNZ with Rcol=0, MAX_ITER=256: exactly 256 write_rcol cycles, then done with err=1. err stays high until the next start, and that start clears it.
- opcode=9 → no writes, done at start+1 with err=1. start pulses during busy are ignored.
- reset asserted in the 2nd LOOP cycle → all outputs 0 next cycle, no done. A new start afterwards runs normally.
